// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl: one-step-per-clock shift-add sequencer for an unsigned WIDTHxWIDTH multiply on an external cla32.
// Optional macro MUL_ZERO_BYPASS_EN: a start with a zero operand finishes in one cycle without stepping the adder.
module mul32_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 op_ready,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_ci,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_co
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_reg;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     p_hi_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic                 op_ready_reg;
    logic                 op_done_reg;

    logic                 step_en;
    logic                 zero_op;
    logic [2*WIDTH-1:0]   shifted;

    assign step_en = (state_reg == RUN);

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (op_a == '0) || (op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // The carry-out becomes the top bit after the shift, so the full 33-bit sum is kept.
    assign shifted = {add_co, add_s, q_reg[WIDTH-1:1]};

    assign add_a  = p_hi_reg;
    assign add_ci = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_add_b
            assign add_b[gi] = m_reg[gi] & q_reg[0] & step_en;
        end
    endgenerate

    assign op_ready = op_ready_reg;
    assign op_done  = op_done_reg;
    assign result   = result_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            m_reg        <= '0;
            q_reg        <= '0;
            p_hi_reg     <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            op_ready_reg <= 1'b1;
            op_done_reg  <= 1'b0;
        end else begin
            op_done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (op_start) begin
                        m_reg    <= op_a;
                        q_reg    <= op_b;
                        p_hi_reg <= '0;
                        cnt_reg  <= '0;
                        if (zero_op) begin
                            q_reg        <= '0;
                            result_reg   <= '0;
                            op_done_reg  <= 1'b1;
                            op_ready_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            op_ready_reg <= 1'b0;
                            state_reg    <= RUN;
                        end
                    end else begin
                        op_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                RUN: begin
                    {p_hi_reg, q_reg} <= shifted;
                    cnt_reg           <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        result_reg   <= shifted;
                        op_done_reg  <= 1'b1;
                        op_ready_reg <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                default: begin
                    op_ready_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end
endmodule
